// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: dispatch, CDB result, issue and
// reservation-station entry records, plus the common operand-capture helper.
package ooo_pkg;

  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ROB_ADDR_WIDTH  = 5;
  localparam int unsigned RS_SIZE_DEFAULT = 8;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } ooo_op_t;

  typedef struct packed {
    logic                      valid;
    logic [ROB_ADDR_WIDTH-1:0] rob_tag;
    logic [DATA_WIDTH-1:0]     data;
  } ooo_result_t;

  typedef struct packed {
    logic                      valid;
    ooo_op_t                   opcode;
    logic [DATA_WIDTH-1:0]     v_rs1;
    logic [DATA_WIDTH-1:0]     v_rs2;
    logic [ROB_ADDR_WIDTH-1:0] rob_tag;
  } ooo_issue_t;

  typedef struct packed {
    ooo_op_t                   opcode;
    logic [ROB_ADDR_WIDTH-1:0] rob_tag;
    logic                      rs1_ready;
    logic [DATA_WIDTH-1:0]     v_rs1;
    logic [ROB_ADDR_WIDTH-1:0] q_rs1;
    logic                      rs2_ready;
    logic [DATA_WIDTH-1:0]     v_rs2;
    logic [ROB_ADDR_WIDTH-1:0] q_rs2;
  } ooo_dispatch_t;

  typedef struct packed {
    logic                      valid;
    ooo_op_t                   opcode;
    logic [ROB_ADDR_WIDTH-1:0] rob_tag;
    logic                      rs1_ready;
    logic [DATA_WIDTH-1:0]     v_rs1;
    logic [ROB_ADDR_WIDTH-1:0] q_rs1;
    logic                      rs2_ready;
    logic [DATA_WIDTH-1:0]     v_rs2;
    logic [ROB_ADDR_WIDTH-1:0] q_rs2;
  } rs_entry_t;

  // Capture a CDB result into any waiting source of a live entry; both
  // sources may match the same producer tag.
  function automatic rs_entry_t rs_capture(rs_entry_t e, ooo_result_t r);
    rs_entry_t res;
    res = e;
    if (e.valid && r.valid) begin
      if (!e.rs1_ready && (e.q_rs1 == r.rob_tag)) begin
        res.rs1_ready = 1'b1;
        res.v_rs1     = r.data;
      end
      if (!e.rs2_ready && (e.q_rs2 == r.rob_tag)) begin
        res.rs2_ready = 1'b1;
        res.v_rs2     = r.data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_oldest_ready_select.sv
// Lowest-index priority picker: index 0 is the oldest entry, so the first
// set candidate bit wins.
import ooo_pkg::*;

module rs_oldest_ready_select #(
  parameter int unsigned RS_SIZE = RS_SIZE_DEFAULT,
  localparam int unsigned IW = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0] cand,
  output logic [RS_SIZE-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               any
);

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (cand[i] && !any) begin
        grant[i] = 1'b1;
        index    = IW'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Unified reservation station: collapsing age-ordered queue that snoops the
// CDB for operands and issues the oldest ready entry.
module reservation_station
  import ooo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = ooo_pkg::DATA_WIDTH,
  parameter int unsigned ROB_ADDR_WIDTH = ooo_pkg::ROB_ADDR_WIDTH,
  parameter int unsigned RS_SIZE        = RS_SIZE_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          dispatch_valid_i,
  output logic          dispatch_ready_o,
  input  ooo_dispatch_t dispatch_i,
  input  ooo_result_t   result_i,
  output ooo_issue_t    issue_o,
  input  logic          issue_ready_i
);

  localparam int unsigned CW = $clog2(RS_SIZE + 1);
  localparam int unsigned IW = $clog2(RS_SIZE);

  // The record types are fixed by the package, so the widths must agree.
  if (RS_SIZE < 2) begin : g_bad_size
    $error("reservation_station: RS_SIZE must be at least 2");
  end
  if (DATA_WIDTH != ooo_pkg::DATA_WIDTH || ROB_ADDR_WIDTH != ooo_pkg::ROB_ADDR_WIDTH) begin : g_bad_width
    $error("reservation_station: widths must match ooo_pkg");
  end

  rs_entry_t         q      [RS_SIZE];
  rs_entry_t         woken  [RS_SIZE];
  rs_entry_t         up     [RS_SIZE];
  rs_entry_t         n      [RS_SIZE];
  rs_entry_t         incoming;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic [CW-1:0]     tail;
  logic [RS_SIZE-1:0] cand;
  logic [RS_SIZE-1:0] grant;
  logic [IW-1:0]     index;
  logic              any;
  logic              dispatch_fire;
  logic              issue_fire;

  assign dispatch_ready_o = (count < CW'(RS_SIZE));

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      cand[i] = q[i].valid && q[i].rs1_ready && q[i].rs2_ready;
    end
  end

  rs_oldest_ready_select #(
    .RS_SIZE(RS_SIZE)
  ) u_select (
    .cand (cand),
    .grant(grant),
    .index(index),
    .any  (any)
  );

  always_comb begin
    issue_o       = '0;
    issue_o.valid = any;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        issue_o.opcode  = q[i].opcode;
        issue_o.v_rs1   = q[i].v_rs1;
        issue_o.v_rs2   = q[i].v_rs2;
        issue_o.rob_tag = q[i].rob_tag;
      end
    end
  end

  always_comb begin
    dispatch_fire = dispatch_valid_i && dispatch_ready_o && !flush_i;
    issue_fire    = any && issue_ready_i && !flush_i;
    tail          = count - CW'(issue_fire);

    incoming           = '0;
    incoming.valid     = 1'b1;
    incoming.opcode    = dispatch_i.opcode;
    incoming.rob_tag   = dispatch_i.rob_tag;
    incoming.rs1_ready = dispatch_i.rs1_ready;
    incoming.v_rs1     = dispatch_i.v_rs1;
    incoming.q_rs1     = dispatch_i.q_rs1;
    incoming.rs2_ready = dispatch_i.rs2_ready;
    incoming.v_rs2     = dispatch_i.v_rs2;
    incoming.q_rs2     = dispatch_i.q_rs2;
    incoming           = rs_capture(incoming, result_i);

    // Wakeup is applied before the collapse so captured data travels with
    // its entry when it shifts down.
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      woken[i] = rs_capture(q[i], result_i);
    end
    for (int unsigned i = 0; i < RS_SIZE - 1; i++) begin
      up[i] = woken[i+1];
    end
    up[RS_SIZE-1] = '0;

    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      n[i] = (issue_fire && (i >= 32'(index))) ? up[i] : woken[i];
      if (dispatch_fire && (CW'(i) == tail)) begin
        n[i] = incoming;
      end
    end
    count_n = count + CW'(dispatch_fire) - CW'(issue_fire);

    if (flush_i) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        n[i] = '0;
      end
      count_n = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        q[i] <= '0;
      end
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        q[i] <= n[i];
      end
      count <= count_n;
    end
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Unified reservation station for the RV32IM out-of-order core. Sits between the dispatch/rename stage and `multiple_execution_units`. It holds dispatched instructions until their source operands are available, snooping the CDB (`ooo_result_t`) to capture results. It issues the oldest ready entry as an `ooo_issue_t` under a valid/ready handshake.

## Interface
- `DATA_WIDTH`, default `ooo_pkg::DATA_WIDTH`: operand width.
- `ROB_ADDR_WIDTH`, default `ooo_pkg::ROB_ADDR_WIDTH`: ROB tag width.
- `RS_SIZE`, default 8: number of entries; must be ≥ 2.
- `clk_i` in 1: single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: pipeline flush; discards all entries.
- `dispatch_valid_i` in 1: dispatch request.
- `dispatch_ready_o` out 1: an entry is free.
- `dispatch_i` in `ooo_dispatch_t`: carries:
  - `opcode` (opcode/funct3/funct7) and `rob_tag`.
  - Per source: `rsN_ready`, `v_rsN` (valid if ready) and `q_rsN` (producer ROB tag if not ready).
- `result_i` in `ooo_result_t`: CDB snoop. Uses `valid`, `rob_tag` and `data`.
- `issue_o` out `ooo_issue_t`: issued instruction. Fields: `valid`, `opcode`, `v_rs1`, `v_rs2`, `rob_tag`.
- `issue_ready_i` in 1: execution units accept `issue_o` this cycle.

## Operation
- **Storage.** `RS_SIZE` `rs_entry_t` registers form a collapsing queue.
  - Index 0 holds the oldest entry. Valid entries are contiguous in `[0, count-1]`.
  - `count` is `$clog2(RS_SIZE+1)` bits wide.
- **Dispatch.** A dispatch fires when `dispatch_valid_i && dispatch_ready_o && !flush_i`.
  - `dispatch_ready_o = (count < RS_SIZE)`, computed from registered `count` only. A same-cycle issue does not free a slot for the same-cycle dispatch.
  - The entry is written at the tail position after any same-cycle collapse.
- **Dispatch bypass.** If an incoming source has `rsN_ready=0` and `result_i.valid && result_i.rob_tag == q_rsN` in the same cycle, the entry is written with `v_rsN = result_i.data` and `rsN_ready=1`.
- **Wakeup.** Each cycle, every valid entry with a not-ready source whose tag matches a valid `result_i` captures the data and sets ready. rs1 and rs2 match independently; both may match the same tag.
- **Select.** A candidate is a valid entry with `rs1_ready && rs2_ready` (registered state).
  - `issue_o` presents the lowest-index candidate. `issue_o.valid=1` iff any candidate exists.
  - `issue_o` is combinational from registered state. It does not depend on `issue_ready_i`.
- **Issue.** An issue fires on `issue_o.valid && issue_ready_i`.
  - The selected entry is removed; entries above it shift down by one.
  - If no issue fires, all entries are retained and selection is re-evaluated next cycle. The presented entry may change if an older entry became ready.
- **Simultaneous issue and dispatch.** `count` is unchanged. The new entry lands at index `count-1` after the shift.
- **Simultaneous wakeup and shift.** A captured value moves with its entry; nothing is lost.
- **Flush.** When `flush_i=1`, next cycle `count=0` and all entries are invalid. Dispatch and issue handshakes in the flush cycle are ignored and state is not updated by them. `issue_o` is still driven combinationally.
- **Entry order.** Entries never reorder except by collapse; relative age is preserved.

## Timing
- **Reset** (async assert, sync deassert at use):
  - `count=0` and all entry valid bits 0.
  - `issue_o.valid=0` with all other `issue_o` fields 0.
  - `dispatch_ready_o=1`.
- **Latencies:**
  - Dispatch of a fully-ready instruction in cycle N → `issue_o.valid` in N+1.
  - CDB broadcast in cycle N that wakes the last operand → issue candidate in N+1.
  - Bypass-at-dispatch in cycle N → candidate in N+1.
- **Throughput:** one dispatch and one issue per cycle.
- **Full:** with `count=RS_SIZE`, `dispatch_ready_o=0` for the entire cycle, even if an issue fires; it recovers the next cycle.
- **Reset mid-operation** clears all entries immediately; in-flight entries are lost.

## Structure
- Add to `ooo_pkg`:
  - `ooo_dispatch_t`.
  - `rs_entry_t` (`valid`, `opcode`, `rob_tag`, `rsN_ready`, `v_rsN`, `q_rsN`).
  - `RS_SIZE_DEFAULT`.
- Reuse the existing `ooo_issue_t` and `ooo_result_t`.
- One sub-module: `rs_oldest_ready_select`, parameterised by `RS_SIZE`.
  - Input: candidate vector. Outputs: one-hot grant, binary index and `any`.
  - Purely combinational lowest-index priority.

## Test plan
- **Fully-ready dispatch.** Reset, dispatch ADD (rob_tag 3, both ready, v_rs1=5, v_rs2=7) with `issue_ready_i=1` → `issue_o.valid=1` next cycle with rob_tag 3, v_rs1=5, v_rs2=7. The following cycle has `count=0`.
- **Wakeup.** Dispatch with rs1 waiting on tag 9. Hold `issue_ready_i=1`; `issue_o.valid` stays 0. Broadcast result tag 9, data 0xDEADBEEF → one cycle later `issue_o.v_rs1=0xDEADBEEF`.
- **Age order.** Dispatch A (waiting on tag 2), B (ready), C (ready) → B issues first. After tag 2 broadcasts, A issues before C.
- **Full and back-pressure.** Fill 8 entries with `issue_ready_i=0` → `dispatch_ready_o=0`. Assert issue together with dispatch → no dispatch accepted that cycle; `dispatch_ready_o=1` next cycle.
- **Bypass at dispatch.** Dispatch with `q_rs2=4` while `result_i` carries tag 4, data 0x11 → issued with `v_rs2=0x11`. Also: `flush_i` with 5 entries → `issue_o.valid=0` and `count=0` next cycle.
- **Reset mid-operation.** Assert `rst_ni=0` asynchronously with 3 entries held → `issue_o.valid=0` immediately and `dispatch_ready_o=1`.
